iq_pair_shifter: RTL and testbench
==================================

Name: iq_pair_shifter

Overview:
- Parameterised successor to the single-channel I/Q arbiter.
- Takes the interleaved ADC sample stream and pairs samples into complex I/Q words, with explicit valid and sync handshakes.
- Applies the Doppler frequency shift using sin/cos from the NCO: out = I*cos − Q*sin, with an optional image term.
- Delivers one pipelined result per pair with a single-cycle valid strobe to the DAC/output path.

Parameters:
- DATA_W, 16: input sample width.
- TRIG_W, 17: width of the signed sin/cos inputs from the NCO.
- OUT_W, 32: output width; must be ≤ DATA_W+TRIG_W+1.
- Q_FIRST, 1: 1 = first sample of a pair is Q; 0 = first sample is I.
- OFFSET_IN, 1: 1 = input is offset-binary, so invert the MSB to get two's complement; 0 = input is already two's complement.
- OFFSET_OUT, 1: 1 = invert the output MSB (offset-binary out); 0 = two's complement out.

Ports:
- M100CLK  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  DATA_W  interleaved sample.
- in_valid  in  1  in_data is valid this cycle.
- in_sync  in  1  qualified by in_valid: this sample is the first of a pair.
- cos_in  in  TRIG_W  signed cosine, sampled as described in Behaviour.
- sin_in  in  TRIG_W  signed sine, sampled as described in Behaviour.
- out_data  out  OUT_W  shifted output, I*cos − Q*sin.
- out_valid  out  1  single-cycle strobe, one per pair.
- slip_count  out  16  count of pair realignments caused by in_sync.
- busy  out  1  high while any pipeline stage holds valid data.

Behaviour:
- Reset (reset=0, asynchronous):
  - Pairing FSM goes to FIRST.
  - All pipeline valids are 0.
  - out_data=0 (raw zero, no offset inversion); out_valid=0; slip_count=0; busy=0.
- Reset release: synchronised internally; the first sample is accepted on the second rising edge after reset deasserts.
- Pairing FSM states: FIRST and SECOND. It advances only on cycles with in_valid=1; in_valid=0 holds state, and gaps of any length are legal.
- In FIRST with a valid sample: latch it as the first sample and go to SECOND. in_sync is allowed and has no extra effect.
- In SECOND with a valid sample and in_sync=0:
  - Latch it as the second sample and complete the pair.
  - Sample cos_in/sin_in on this same edge.
  - Go to FIRST.
- In SECOND with a valid sample and in_sync=1 (slip):
  - Discard the held first sample.
  - Latch the current sample as the new first sample and stay in SECOND.
  - slip_count increments, saturating at 0xFFFF.
  - No output is produced for the discarded sample.
- Sample mapping:
  - Q_FIRST=1: first sample is Q, second is I. Q_FIRST=0 swaps them.
  - OFFSET_IN=1: the MSB is inverted before any arithmetic.
- Pipeline:
  - Edge k (pair completes): stage 0 registers I, Q, cos, sin (signed).
  - Edge k+1: the four signed products, each DATA_W+TRIG_W bits.
  - Edge k+2: S = I*cos − Q*sin, DATA_W+TRIG_W+1 bits, no overflow possible.
  - Edge k+3: out_data = S >>> (DATA_W+TRIG_W+1−OUT_W), arithmetic truncation toward −inf, MSB inverted if OFFSET_OUT=1. out_valid=1 for exactly this one cycle.
- Latency: 3 cycles from the pair-completing edge to out_valid. Throughput is one pair per 2 valid samples, so back-to-back pairs give out_valid every other cycle.
- out_data holds its last value while out_valid=0.
- busy = OR of the stage valids and out_valid.
- The pipeline never stalls; there is no downstream ready.
- Reset asserted mid-operation:
  - Immediately clears all valids and outputs.
  - Every in-flight pair is lost, with no partial output.
  - slip_count is cleared.

Optional Feature:
- Macro: IQ_IMAGE_OUT_EN.
- When defined:
  - Adds port out_image, out, OUT_W bits, = I*sin + Q*cos.
  - Same width rule, truncation, OFFSET_OUT handling, latency and strobe (shares out_valid) as out_data.
  - Reset value 0.
- When undefined: the port and its adder are absent, and out_data timing is unchanged.

Test Plan:
- Default parameters. Valid stream 0x8000 (Q=0), then 0xC000 (I=16384), with cos_in=32768, sin_in=0 on the second edge. Expect out_valid exactly 3 cycles later with out_data=0x88000000, and out_valid high for one cycle.
- Q=0xC000, I=0x8000, cos=0, sin=32768. Expect out_data=0x78000000 (S=−2^29).
- With IQ_IMAGE_OUT_EN defined: Q=I=0xC000, cos=sin=32768. Expect out_data=0x80000000 and out_image=0x90000000.
- Send Q sample, then in_sync=1 on the next valid sample, then a normal second sample. Expect slip_count=1 and exactly one out_valid, computed from the last two samples.
- in_valid toggling 1,0,0,1: the pair completes only on the second valid sample, and no output comes from the idle cycles.
- Drive reset low one cycle after a pair completes. Expect out_valid, out_data, busy and slip_count all 0 immediately, and no output after reset releases until a new pair completes.

Source files
------------

// File: rtl/iq_pair_shifter.sv
// Pairs interleaved ADC samples into I/Q words and applies out = I*cos - Q*sin (IQ_IMAGE_OUT_EN adds out_image = I*sin + Q*cos).
// Latency: 3 cycles from the pair-completing edge to the one-cycle out_valid strobe; one pair per two valid samples.
// Backpressure: none; the pipeline never stalls and downstream must accept every strobe.
module iq_pair_shifter #(
    parameter int DATA_W     = 16,
    parameter int TRIG_W     = 17,
    parameter int OUT_W      = 32,
    parameter int Q_FIRST    = 1,
    parameter int OFFSET_IN  = 1,
    parameter int OFFSET_OUT = 1
) (
    input  logic              M100CLK,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_sync,
    input  logic [TRIG_W-1:0] cos_in,
    input  logic [TRIG_W-1:0] sin_in,
    output logic [OUT_W-1:0]  out_data,
`ifdef IQ_IMAGE_OUT_EN
    output logic [OUT_W-1:0]  out_image,
`endif
    output logic              out_valid,
    output logic [15:0]       slip_count,
    output logic              busy
);
    localparam int PROD_W = DATA_W + TRIG_W;
    localparam int SUM_W  = PROD_W + 1;
    localparam int SHIFT  = SUM_W - OUT_W;
    localparam logic [DATA_W-1:0] IN_FLIP  = (OFFSET_IN != 0)  ? {1'b1, {(DATA_W-1){1'b0}}} : '0;
    localparam logic [OUT_W-1:0]  OUT_FLIP = (OFFSET_OUT != 0) ? {1'b1, {(OUT_W-1){1'b0}}}  : '0;

    typedef enum logic {ST_FIRST, ST_SECOND} state_t;

    state_t                   state_q;
    logic                     run_q;
    logic                     accept_d;
    logic [DATA_W-1:0]        samp_d;
    logic [DATA_W-1:0]        first_q;
    logic [15:0]              slip_q;
    logic                     v0_q, v1_q, v2_q, out_valid_q;
    logic signed [DATA_W-1:0] i0_q, q0_q;
    logic signed [TRIG_W-1:0] cos0_q, sin0_q;
    logic signed [PROD_W-1:0] p_ic_q, p_qs_q;
    logic signed [SUM_W-1:0]  s_q, s_d;
    logic [OUT_W-1:0]         out_data_q;
`ifdef IQ_IMAGE_OUT_EN
    logic signed [PROD_W-1:0] p_is_q, p_qc_q;
    logic signed [SUM_W-1:0]  im_q, im_d;
    logic [OUT_W-1:0]         out_image_q;
`endif

    assign samp_d   = in_data ^ IN_FLIP;
    assign accept_d = in_valid & run_q;

    // Single-flop release gate: nothing is accepted on the first edge after reset deasserts.
    always_ff @(posedge M100CLK or negedge reset) begin
        if (!reset) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Pairing FSM; also loads pipeline stage 0 on the pair-completing edge.
    always_ff @(posedge M100CLK or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FIRST;
            first_q <= '0;
            slip_q  <= '0;
            v0_q    <= 1'b0;
            i0_q    <= '0;
            q0_q    <= '0;
            cos0_q  <= '0;
            sin0_q  <= '0;
        end else begin
            v0_q <= 1'b0;
            if (accept_d) begin
                case (state_q)
                    ST_FIRST: begin
                        first_q <= samp_d;
                        state_q <= ST_SECOND;
                    end
                    ST_SECOND: begin
                        if (in_sync) begin
                            first_q <= samp_d;
                            if (slip_q != 16'hFFFF) begin
                                slip_q <= slip_q + 16'd1;
                            end
                        end else begin
                            v0_q    <= 1'b1;
                            cos0_q  <= cos_in;
                            sin0_q  <= sin_in;
                            state_q <= ST_FIRST;
                            if (Q_FIRST != 0) begin
                                q0_q <= first_q;
                                i0_q <= samp_d;
                            end else begin
                                i0_q <= first_q;
                                q0_q <= samp_d;
                            end
                        end
                    end
                    default: state_q <= ST_FIRST;
                endcase
            end
        end
    end

    assign s_d = SUM_W'(p_ic_q) - SUM_W'(p_qs_q);
`ifdef IQ_IMAGE_OUT_EN
    assign im_d = SUM_W'(p_is_q) + SUM_W'(p_qc_q);
`endif

    always_ff @(posedge M100CLK or negedge reset) begin
        if (!reset) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            p_ic_q      <= '0;
            p_qs_q      <= '0;
            s_q         <= '0;
            out_data_q  <= '0;
`ifdef IQ_IMAGE_OUT_EN
            p_is_q      <= '0;
            p_qc_q      <= '0;
            im_q        <= '0;
            out_image_q <= '0;
`endif
        end else begin
            v1_q        <= v0_q;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
            if (v0_q) begin
                p_ic_q <= PROD_W'(i0_q) * PROD_W'(cos0_q);
                p_qs_q <= PROD_W'(q0_q) * PROD_W'(sin0_q);
`ifdef IQ_IMAGE_OUT_EN
                p_is_q <= PROD_W'(i0_q) * PROD_W'(sin0_q);
                p_qc_q <= PROD_W'(q0_q) * PROD_W'(cos0_q);
`endif
            end
            if (v1_q) begin
                s_q <= s_d;
`ifdef IQ_IMAGE_OUT_EN
                im_q <= im_d;
`endif
            end
            // Arithmetic shift keeps the top OUT_W bits, rounding toward -inf.
            if (v2_q) begin
                out_data_q <= OUT_W'(s_q >>> SHIFT) ^ OUT_FLIP;
`ifdef IQ_IMAGE_OUT_EN
                out_image_q <= OUT_W'(im_q >>> SHIFT) ^ OUT_FLIP;
`endif
            end
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign slip_count = slip_q;
    assign busy       = v0_q | v1_q | v2_q | out_valid_q;
`ifdef IQ_IMAGE_OUT_EN
    assign out_image  = out_image_q;
`endif

endmodule

// File: tb/tb_iq_pair_shifter.sv
// Bench for iq_pair_shifter at default parameters: directed cases plus random traffic against an arithmetic model.
module tb_iq_pair_shifter;
    logic        M100CLK  = 1'b0;
    logic        reset    = 1'b1;
    logic [15:0] in_data  = '0;
    logic        in_valid = 1'b0;
    logic        in_sync  = 1'b0;
    logic [16:0] cos_in   = '0;
    logic [16:0] sin_in   = '0;
    logic [31:0] out_data;
`ifdef IQ_IMAGE_OUT_EN
    logic [31:0] out_image;
`endif
    logic        out_valid;
    logic [15:0] slip_count;
    logic        busy;

    iq_pair_shifter dut (
        .M100CLK   (M100CLK),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sync   (in_sync),
        .cos_in    (cos_in),
        .sin_in    (sin_in),
        .out_data  (out_data),
`ifdef IQ_IMAGE_OUT_EN
        .out_image (out_image),
`endif
        .out_valid (out_valid),
        .slip_count(slip_count),
        .busy      (busy)
    );

    always #5 M100CLK = ~M100CLK;

    typedef struct {
        int          due;
        logic [31:0] d;
        logic [31:0] im;
    } exp_t;

    exp_t        expq[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          rel_edges = 0;
    bit          have_first = 1'b0;
    longint      first_v = 0;
    int          slip_m = 0;
    logic [31:0] last_out = '0;
`ifdef IQ_IMAGE_OUT_EN
    logic [31:0] last_im = '0;
`endif

    function automatic longint from_offset(input logic [15:0] raw);
        return longint'(raw) - 32768;
    endfunction

    // Floor-divide by 4 (34-bit sum down to 32 bits), then re-bias to offset binary.
    function automatic logic [31:0] to_out(input longint s);
        longint t;
        t = (s >= 0) ? (s / 4) : -((-s + 3) / 4);
        return 32'(t + longint'(32'h8000_0000));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic model_edge(input bit v, input bit s, input logic [15:0] d,
                              input logic [16:0] c, input logic [16:0] sn);
        longint cur, iv, qv, cv, sv;
        exp_t   e;
        if (reset && rel_edges >= 2 && v) begin
            cur = from_offset(d);
            if (!have_first) begin
                first_v    = cur;
                have_first = 1'b1;
            end else if (s) begin
                first_v = cur;
                if (slip_m < 65535) slip_m++;
            end else begin
                qv    = first_v;
                iv    = cur;
                cv    = longint'($signed(c));
                sv    = longint'($signed(sn));
                e.due = cyc + 3;
                e.d   = to_out(iv * cv - qv * sv);
                e.im  = to_out(iv * sv + qv * cv);
                expq.push_back(e);
                have_first = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        bit due_now;
        bit busy_e;
        busy_e  = (expq.size() != 0);
        due_now = busy_e && (expq[0].due == cyc);
        chk("out_valid", 32'(out_valid), 32'(due_now));
        if (due_now) begin
            last_out = expq[0].d;
`ifdef IQ_IMAGE_OUT_EN
            last_im  = expq[0].im;
`endif
            expq.delete(0);
        end
        chk("out_data", out_data, last_out);
`ifdef IQ_IMAGE_OUT_EN
        chk("out_image", out_image, last_im);
`endif
        chk("busy", 32'(busy), 32'(busy_e));
        chk("slip_count", 32'(slip_count), 32'(slip_m));
    endtask

    task automatic step(input bit v, input bit s, input logic [15:0] d,
                        input logic [16:0] c, input logic [16:0] sn);
        in_valid = v;
        in_sync  = s;
        in_data  = d;
        cos_in   = c;
        sin_in   = sn;
        @(posedge M100CLK);
        cyc++;
        if (reset) rel_edges++;
        model_edge(v, s, d, c, sn);
        #1;
        check_outputs();
        in_valid = 1'b0;
        in_sync  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'h0, 17'h0, 17'h0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        expq.delete();
        have_first = 1'b0;
        slip_m     = 0;
        last_out   = '0;
`ifdef IQ_IMAGE_OUT_EN
        last_im    = '0;
`endif
        rel_edges  = 0;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_slip_count", 32'(slip_count), 32'h0);
    endtask

    task automatic release_reset();
        reset     = 1'b1;
        rel_edges = 0;
    endtask

    initial begin
        logic [15:0] rd;
        logic [16:0] rc, rs;
        bit          rv, rsy;

        #2;
        do_reset();
        idle(2);
        release_reset();
        idle(2);

        // Q=0, I=16384, cos=32768, sin=0 -> S=2^29
        step(1'b1, 1'b0, 16'h8000, 17'h0, 17'h0);
        step(1'b1, 1'b0, 16'hC000, 17'h08000, 17'h0);
        idle(3);
        chk("t1_out_data", out_data, 32'h8800_0000);
        idle(1);

        // Q=16384, I=0, cos=0, sin=32768 -> S=-2^29
        step(1'b1, 1'b0, 16'hC000, 17'h0, 17'h0);
        step(1'b1, 1'b0, 16'h8000, 17'h0, 17'h08000);
        idle(3);
        chk("t2_out_data", out_data, 32'h7800_0000);

        // Q=I=16384, cos=sin=32768 -> S=0, image=2^30
        step(1'b1, 1'b0, 16'hC000, 17'h0, 17'h0);
        step(1'b1, 1'b0, 16'hC000, 17'h08000, 17'h08000);
        idle(3);
        chk("t3_out_data", out_data, 32'h8000_0000);
`ifdef IQ_IMAGE_OUT_EN
        chk("t3_out_image", out_image, 32'h9000_0000);
`endif

        // Slip: the held first sample is dropped, pair is formed from the last two.
        step(1'b1, 1'b0, 16'h1234, 17'h0, 17'h0);
        step(1'b1, 1'b1, 16'h4321, 17'h0, 17'h0);
        step(1'b1, 1'b0, 16'hABCD, 17'h1F00F, 17'h03A5C);
        idle(3);
        chk("t4_slip_count", 32'(slip_count), 32'd1);
        idle(1);

        // Gaps between the two samples of a pair.
        step(1'b1, 1'b0, 16'h7FFF, 17'h0, 17'h0);
        idle(2);
        step(1'b1, 1'b0, 16'h0001, 17'h10000, 17'h0FFFF);
        idle(4);

        // Reset one cycle after a pair completes; in-flight result must be lost.
        step(1'b1, 1'b0, 16'h9000, 17'h0, 17'h0);
        step(1'b1, 1'b0, 16'h3000, 17'h05555, 17'h1AAAA);
        idle(1);
        do_reset();
        idle(2);
        release_reset();
        // First edge after release is ignored; the next two form a pair.
        step(1'b1, 1'b0, 16'hFFFF, 17'h0, 17'h0);
        step(1'b1, 1'b0, 16'h2222, 17'h0, 17'h0);
        step(1'b1, 1'b0, 16'hEEEE, 17'h0C000, 17'h04000);
        idle(5);

        for (int n = 0; n < 400; n++) begin
            rv  = ($urandom_range(0, 9) < 7);
            rsy = ($urandom_range(0, 6) == 0);
            rd  = 16'($urandom);
            rc  = 17'($urandom);
            rs  = 17'($urandom);
            step(rv, rsy, rd, rc, rs);
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
                idle(1);
                release_reset();
            end
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
